i2s_rx_master: RTL and testbench

- I2S clock master and deserializer for the sonar microphone array.
- Generates the shared SCK/WS for both mic data lines (high and low pair).
- Captures 24-bit samples from NUM_LINES stereo SD lines.
- Emits them as an AXI-Stream of sign-extended 32-bit words, one beat per channel, feeding the block-design capture path toward DDR.

---
 rtl/i2s_rx_master.sv | 186 ++++++++++++++++++
 tb/tb_i2s_rx_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_master.sv
// I2S clock master and multi-line deserializer.
//
// Generates SCK/WS for NUM_LINES stereo SD lines and captures SAMPLE_BITS-wide
// samples from each line. A completed frame (all 2*NUM_LINES channels) is
// copied into a one-frame output buffer and streamed out over AXI-Stream as
// sign-extended 32-bit words, channel index = 2*line + slot (0 = left).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   enable              run request; low stops SCK/WS and discards the partial frame
//   sck, ws             registered I2S bit clock and word select (0 = left)
//   sd[NUM_LINES]       serial data, asynchronous to clk
//   m_axis_*            output stream (tdata, tuser, tlast, tvalid, tready)
//   overrun             sticky flag: a completed frame found the buffer busy
//   overrun_clr         clears overrun (a coincident set wins)
//   frame_cnt           frames accepted into the output buffer, wraps
module i2s_rx_master #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 24,
  parameter int NUM_LINES   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  output logic                           sck,
  output logic                           ws,
  input  logic [NUM_LINES-1:0]           sd,
  output logic [31:0]                    m_axis_tdata,
  output logic [$clog2(2*NUM_LINES)-1:0] m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           overrun,
  input  logic                           overrun_clr,
  output logic [31:0]                    frame_cnt
);

  localparam int NUM_CH = 2 * NUM_LINES;
  localparam int CH_W   = $clog2(NUM_CH);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  // Slot bit windows; bc=0 and bc=32 carry the I2S one-bit delay.
  localparam logic [5:0] L_FIRST = 6'd1;
  localparam logic [5:0] L_LAST  = 6'(SAMPLE_BITS);
  localparam logic [5:0] R_FIRST = 6'd33;
  localparam logic [5:0] R_LAST  = 6'(32 + SAMPLE_BITS);

  function automatic logic signed [31:0] sign_ext(input logic [SAMPLE_BITS-1:0] v);
    return {{(32 - SAMPLE_BITS){v[SAMPLE_BITS-1]}}, v};
  endfunction

  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

  logic [NUM_LINES-1:0]                    r_sd_p0, r_sd_p1;
  logic [7:0]                              r_div;
  logic                                    r_sck, r_ws;
  logic [5:0]                              r_bc;
  logic [5:0]                              w_bc_inc;
  logic                                    w_cap, w_frame_done, w_load, w_drop;
  logic [NUM_LINES-1:0][SAMPLE_BITS-1:0]   r_shl, r_shr;
  logic [NUM_CH-1:0][SAMPLE_BITS-1:0]      r_buf;
  state_t                                  r_state, w_state_nxt;
  logic [CH_W-1:0]                         r_ch, w_ch_nxt;
  logic                                    w_last;
  logic                                    r_overrun;
  logic [31:0]                             r_frame_cnt;

  // Stage p0/p1: two-flop synchronizer for the asynchronous SD lines.
  always_ff @(posedge clk) begin
    r_sd_p0 <= sd;
    r_sd_p1 <= r_sd_p0;
  end

  // SCK divider and bit counter. WS takes the post-increment bc[5] so it only
  // moves on the SCK falling edge.
  assign w_bc_inc = r_bc + 6'd1;
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_div <= '0;
      r_sck <= 1'b0;
      r_bc  <= '0;
      r_ws  <= 1'b0;
    end else if (r_div == DIV_MAX) begin
      r_div <= '0;
      r_sck <= ~r_sck;
      if (r_sck) begin
        r_bc <= w_bc_inc;
        r_ws <= w_bc_inc[5];
      end
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  // Capture happens on the clk edge where SCK goes 1->0; r_bc still names the
  // bit that was on the line during the SCK period just ending.
  assign w_cap        = enable && (r_div == DIV_MAX) && r_sck;
  assign w_frame_done = w_cap && (r_bc == 6'd63);
  assign w_load       = w_frame_done && (r_state == S_IDLE);
  assign w_drop       = w_frame_done && (r_state == S_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shl <= '0;
      r_shr <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (r_bc >= L_FIRST && r_bc <= L_LAST)
          r_shl[i] <= {r_shl[i][SAMPLE_BITS-2:0], r_sd_p1[i]};
        if (r_bc >= R_FIRST && r_bc <= R_LAST)
          r_shr[i] <= {r_shr[i][SAMPLE_BITS-2:0], r_sd_p1[i]};
      end
    end
  end

  // Frame buffer, accept counter and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        for (int i = 0; i < NUM_LINES; i++) begin
          r_buf[2*i]   <= r_shl[i];
          r_buf[2*i+1] <= r_shr[i];
        end
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
      if (w_drop)
        r_overrun <= 1'b1;
      else if (overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  // Output FSM: the buffer counts as busy for as long as it is in S_SEND.
  assign w_last = (r_ch == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    unique case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_SEND;
          w_ch_nxt    = '0;
        end
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = '0;
          end else begin
            w_ch_nxt = r_ch + CH_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ch_nxt    = '0;
      end
    endcase
  end

  assign sck           = r_sck;
  assign ws            = r_ws;
  assign m_axis_tvalid = (r_state == S_SEND);
  assign m_axis_tdata  = m_axis_tvalid ? 32'(sign_ext(r_buf[r_ch])) : 32'd0;
  assign m_axis_tuser  = r_ch;
  assign m_axis_tlast  = m_axis_tvalid && w_last;
  assign overrun       = r_overrun;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_i2s_rx_master.sv
`timescale 1ns/1ps
module tb_i2s_rx_master;

  localparam int NL  = 2;
  localparam int NCH = 2 * NL;

  logic          clk = 1'b0;
  logic          rst, enable, sck, ws;
  logic [NL-1:0] sd;
  logic [31:0]   tdata;
  logic [1:0]    tuser;
  logic          tlast, tvalid, tready;
  logic          overrun, overrun_clr;
  logic [31:0]   frame_cnt;

  always #5 clk = ~clk;

  i2s_rx_master #(.CLK_DIV(4), .SAMPLE_BITS(24), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sck(sck), .ws(ws), .sd(sd),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .overrun(overrun), .overrun_clr(overrun_clr), .frame_cnt(frame_cnt)
  );

  typedef struct { logic [NCH-1:0][23:0] w; bit ex; } frame_t;
  typedef struct { logic [31:0] data; logic [1:0] user; logic last; } beat_t;

  int     total = 0, bad = 0;
  frame_t dir_q[$];
  beat_t  sb[$];
  frame_t cur;
  int     p = 0, frames_done = 0, acc_cnt = 0, beats = 0;
  bit     in_frame = 0, default_ex = 1, rnd_ready = 0, fix_ready = 1;
  logic [31:0] log_data [4];
  logic        log_last [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 24-bit two's complement value expressed as a 32-bit word.
  function automatic logic [31:0] sx24(input logic [23:0] v);
    int s;
    s = int'(v);
    if (s >= 8388608) s = s - 16777216;
    return 32'(s);
  endfunction

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired", name);
  endtask

  task automatic wait_fd(input int target, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin step(); n++; end
    if (frames_done < target) timeout_fail(name);
  endtask

  task automatic wait_dirq(input int k, input string name);
    int n;
    n = 0;
    while (dir_q.size() > k && n < 3000) begin step(); n++; end
    if (dir_q.size() > k) timeout_fail(name);
  endtask

  function automatic frame_t rnd_frame(input bit ex);
    frame_t f;
    for (int c = 0; c < NCH; c++) f.w[c] = 24'($urandom);
    f.ex = ex;
    return f;
  endfunction

  // I2S transmitter model: slot position p counts SCK falling edges within a
  // 64-bit frame; position 1.. carries the left MSB, 33.. the right MSB.
  // Expected beats are queued when a frame starts transmitting.
  initial begin : bfm
    logic  prev_sck;
    beat_t b;
    prev_sck = 1'b0;
    sd       = '1;
    cur.w    = '0;
    cur.ex   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !enable) begin
        p        = 0;
        in_frame = 1'b0;
      end else if (prev_sck && !sck) begin
        if (p == 63 && in_frame) begin
          frames_done++;
          if (cur.ex) acc_cnt++;
          in_frame = 1'b0;
        end
        p = (p + 1) % 64;
        chk("ws_slot", 64'(ws), 64'(p >= 32));
        if (p == 1) begin
          if (dir_q.size() > 0) cur = dir_q.pop_front();
          else cur = rnd_frame(default_ex);
          in_frame = 1'b1;
          if (cur.ex) begin
            for (int c = 0; c < NCH; c++) begin
              b.data = sx24(cur.w[c]);
              b.user = 2'(c);
              b.last = (c == NCH - 1);
              sb.push_back(b);
            end
          end
        end
      end
      prev_sck = sck;
      for (int l = 0; l < NL; l++) begin
        if (p >= 1 && p <= 24)       sd[l] = cur.w[2*l][24-p];
        else if (p >= 33 && p <= 56) sd[l] = cur.w[2*l+1][56-p];
        else if (p == 0 || p == 32)  sd[l] = 1'b1;
        else                         sd[l] = 1'($urandom);
      end
    end
  end

  initial begin : ready_drv
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rnd_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
    end
  end

  initial begin : monitor
    logic        stall, pws, psck, pen, prst;
    logic [34:0] held;
    beat_t       e;
    stall = 1'b0; pws = 1'b0; psck = 1'b0; pen = 1'b0; prst = 1'b1; held = '0;
    forever begin
      @(negedge clk);
      if (stall && tvalid && !rst)
        chk("hold", 64'({tdata, tuser, tlast}), 64'(held));
      if (enable && pen && !rst && !prst && (ws !== pws))
        chk("ws_edge", 64'({psck, sck}), 64'(2'b10));
      if (tvalid && tready) begin
        beats++;
        log_data[tuser] = tdata;
        log_last[tuser] = tlast;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got data %h user %0d, want no beat", tdata, tuser);
        end else begin
          e = sb.pop_front();
          chk("beat", 64'({tdata, tuser, tlast}), 64'({e.data, e.user, e.last}));
        end
      end
      stall = tvalid && !tready;
      held  = {tdata, tuser, tlast};
      pws = ws; psck = sck; pen = enable; prst = rst;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int     r1, r2, wsr, fd0, b0, n;
    logic   psck;
    frame_t f;

    rst = 1'b1; enable = 1'b1; overrun_clr = 1'b0;
    repeat (5) step();
    chk("rst_sck",       64'(sck),       64'(0));
    chk("rst_ws",        64'(ws),        64'(0));
    chk("rst_tvalid",    64'(tvalid),    64'(0));
    chk("rst_tlast",     64'(tlast),     64'(0));
    chk("rst_tdata",     64'(tdata),     64'(0));
    chk("rst_tuser",     64'(tuser),     64'(0));
    chk("rst_overrun",   64'(overrun),   64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    rst = 1'b0;

    r1 = -1; r2 = -1; wsr = -1; psck = 1'b0;
    for (int k = 1; k <= 400 && wsr < 0; k++) begin
      step();
      if (sck && !psck) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      psck = sck;
      if (ws && wsr < 0) wsr = k;
    end
    chk("first_sck_rise", 64'(r1), 64'(4));
    chk("sck_period",     64'(r2 - r1), 64'(8));
    chk("first_ws_rise",  64'(wsr), 64'(256));

    // Directed frame with the full-scale corner values.
    f.w[0] = 24'h123456; f.w[1] = 24'hFEDCBA; f.w[2] = 24'h7FFFFF; f.w[3] = 24'h800000;
    f.ex = 1'b1;
    dir_q.push_back(f);
    wait_dirq(0, "dir_pop");
    fd0 = frames_done;
    wait_fd(fd0 + 1, "dir_frame");
    repeat (10) step();
    chk("dir_ch0",   64'(log_data[0]), 64'(32'h00123456));
    chk("dir_ch1",   64'(log_data[1]), 64'(32'hFFFEDCBA));
    chk("dir_ch2",   64'(log_data[2]), 64'(32'h007FFFFF));
    chk("dir_ch3",   64'(log_data[3]), 64'(32'hFF800000));
    chk("dir_last3", 64'(log_last[3]), 64'(1));
    chk("dir_last0", 64'(log_last[0]), 64'(0));
    chk("dir_frame_cnt", 64'(frame_cnt), 64'(acc_cnt));

    // Random frames under random backpressure.
    rnd_ready = 1'b1;
    fd0 = frames_done;
    wait_fd(fd0 + 5, "rand_frames");
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(acc_cnt));

    // Backpressure: frame A parks in the buffer, frame B is dropped.
    rnd_ready = 1'b0; fix_ready = 1'b1;
    dir_q.push_back(rnd_frame(1'b1));
    dir_q.push_back(rnd_frame(1'b0));
    wait_dirq(1, "bp_popA");
    fd0 = frames_done;
    repeat (20) step();
    fix_ready = 1'b0;
    wait_fd(fd0 + 2, "bp_frames");
    enable = 1'b0;
    repeat (3) step();
    chk("bp_overrun",   64'(overrun),   64'(1));
    chk("bp_frame_cnt", 64'(frame_cnt), 64'(acc_cnt));
    chk("bp_stalled",   64'(tvalid),    64'(1));
    b0 = beats;
    fix_ready = 1'b1;
    n = 0;
    while (beats < b0 + 4 && n < 100) begin step(); n++; end
    chk("bp_drain_beats", 64'(beats - b0), 64'(4));
    repeat (3) step();
    chk("bp_idle", 64'(tvalid), 64'(0));
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    step();
    chk("overrun_clr", 64'(overrun), 64'(0));

    // Mid-frame disable at bc=20, then a clean frame after re-enable.
    enable = 1'b1; rnd_ready = 1'b1;
    dir_q.push_back(rnd_frame(1'b0));
    dir_q.push_back(rnd_frame(1'b1));
    wait_dirq(1, "mid_popD");
    n = 0;
    while (!(p == 20 && sck) && n < 1000) begin step(); n++; end
    if (!(p == 20 && sck)) timeout_fail("mid_bc20");
    enable = 1'b0;
    b0 = beats;
    step();
    chk("mid_sck", 64'(sck), 64'(0));
    chk("mid_ws",  64'(ws),  64'(0));
    repeat (100) step();
    chk("mid_no_beats", 64'(beats - b0), 64'(0));
    enable = 1'b1;
    wait_dirq(0, "mid_popE");
    fd0 = frames_done;
    wait_fd(fd0 + 1, "mid_frameE");
    repeat (20) step();
    chk("mid_frame_cnt", 64'(frame_cnt), 64'(acc_cnt));

    // Reset while a beat is stalled.
    rnd_ready = 1'b0; fix_ready = 1'b0;
    repeat (3) step();
    n = 0;
    while (!tvalid && n < 1500) begin step(); n++; end
    if (!tvalid) timeout_fail("rst_wait_tvalid");
    enable = 1'b0;
    rst = 1'b1;
    step();
    chk("mrst_tvalid",    64'(tvalid),    64'(0));
    chk("mrst_tlast",     64'(tlast),     64'(0));
    chk("mrst_tdata",     64'(tdata),     64'(0));
    chk("mrst_frame_cnt", 64'(frame_cnt), 64'(0));
    sb.delete();
    acc_cnt = 0;
    rst = 1'b0;
    fix_ready = 1'b1;
    b0 = beats;
    repeat (50) step();
    chk("mrst_no_stale", 64'(beats - b0), 64'(0));

    enable = 1'b1; rnd_ready = 1'b1;
    fd0 = frames_done;
    wait_fd(fd0 + 2, "post_rst_frames");
    enable = 1'b0;
    repeat (60) step();
    chk("end_frame_cnt", 64'(frame_cnt), 64'(acc_cnt));
    chk("end_sb_empty",  64'(sb.size()), 64'(0));
    chk("end_idle",      64'(tvalid),    64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
